// File: rtl/issue_ctrl.sv
// issue_ctrl: single-entry issue stage with a register scoreboard that tracks
// outstanding long-latency writebacks and drains before system/CSR instructions.
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 16
`endif
`ifndef DECINFO_GRP_BUS
`define DECINFO_GRP_BUS 2:0
`define DECINFO_GRP_WIDTH 3
`define DECINFO_GRP_ALU 3'd0
`define DECINFO_GRP_BJP 3'd1
`define DECINFO_GRP_MULDIV 3'd2
`define DECINFO_GRP_CSR 3'd3
`define DECINFO_GRP_MEM 3'd4
`define DECINFO_GRP_SYS 3'd5
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module issue_ctrl #(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dec_valid_i,
  output logic                       dec_ready_o,
  input  logic [`DECINFO_WIDTH-1:0]  dec_info_i,
  input  logic [`REG_ADDR_WIDTH-1:0] reg1_raddr_i,
  input  logic [`REG_ADDR_WIDTH-1:0] reg2_raddr_i,
  input  logic                       reg_we_i,
  input  logic [`REG_ADDR_WIDTH-1:0] reg_waddr_i,
  output logic                       issue_valid_o,
  input  logic                       ex_ready_i,
  output logic [`DECINFO_WIDTH-1:0]  issue_info_o,
  output logic                       issue_reg_we_o,
  output logic [`REG_ADDR_WIDTH-1:0] issue_reg_waddr_o,
  output logic                       issue_long_o,
  input  logic                       wb_valid_i,
  input  logic [`REG_ADDR_WIDTH-1:0] wb_waddr_i,
  input  logic                       flush_i,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [`DECINFO_WIDTH-1:0]   info_q, info_d;
  logic                        we_q, we_d, long_q, long_d;
  logic [`REG_ADDR_WIDTH-1:0]  waddr_q, waddr_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0]                 pending_q, pending_d, set_mask_s, clr_mask_s;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic [`DECINFO_GRP_WIDTH-1:0] dec_grp_s;
  logic dec_long_s, dec_drain_s, hazard_s, at_limit_s;
  logic issue_raw_s, issue_valid_s, issue_fire_s, accept_s, dec_ready_s;
  logic cnt_inc_s, cnt_dec_s;

  assign dec_grp_s   = dec_info_i[`DECINFO_GRP_BUS];
  assign dec_long_s  = (dec_grp_s == `DECINFO_GRP_MULDIV) |
                       ((dec_grp_s == `DECINFO_GRP_MEM) & reg_we_i);
  assign dec_drain_s = (dec_grp_s == `DECINFO_GRP_SYS) | (dec_grp_s == `DECINFO_GRP_CSR);

  // Hazards use registered pending only; a writeback unblocks on the next cycle.
  assign hazard_s   = pending_q[rs1_q] | pending_q[rs2_q] | (we_q & pending_q[waddr_q]);
  assign at_limit_s = (cnt_q == CNT_W'(MAX_OUT));

  // Issue qualification per held-entry state.
  always_comb begin
    issue_raw_s = 1'b0;
    case (state_q)
      ST_HOLD:  issue_raw_s = ~hazard_s & ~(long_q & at_limit_s);
      ST_DRAIN: issue_raw_s = (pending_q == 32'd0) & (cnt_q == {CNT_W{1'b0}});
      default:  issue_raw_s = 1'b0;
    endcase
  end

  assign issue_valid_s = ~flush_i & issue_raw_s;
  assign issue_fire_s  = issue_valid_s & ex_ready_i;
  assign dec_ready_s   = ~flush_i & ((state_q == ST_EMPTY) | issue_fire_s);
  assign accept_s      = dec_valid_i & dec_ready_s;

  assign cnt_inc_s  = issue_fire_s & long_q;
  assign cnt_dec_s  = wb_valid_i & (cnt_q != {CNT_W{1'b0}});
  assign set_mask_s = (cnt_inc_s & (waddr_q != {`REG_ADDR_WIDTH{1'b0}})) ?
                      (32'd1 << waddr_q) : 32'd0;
  assign clr_mask_s = wb_valid_i ? (32'd1 << wb_waddr_i) : 32'd0;

  // Entry, FSM and scoreboard next-state.
  always_comb begin
    state_d   = state_q;
    info_d    = info_q;
    we_d      = we_q;
    long_d    = long_q;
    waddr_d   = waddr_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else if (accept_s) begin
      state_d = dec_drain_s ? ST_DRAIN : ST_HOLD;
      info_d  = dec_info_i;
      we_d    = reg_we_i;
      long_d  = dec_long_s;
      waddr_d = reg_waddr_i;
      rs1_d   = reg1_raddr_i;
      rs2_d   = reg2_raddr_i;
    end else if (issue_fire_s) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
    // A same-register set wins over the clear: the new producer is outstanding.
    pending_d = ((pending_q & ~clr_mask_s) | set_mask_s) & ~32'd1;
    case ({cnt_inc_s, cnt_dec_s})
      2'b10:   cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (wb_valid_i & ((cnt_q == {CNT_W{1'b0}}) |
            ((wb_waddr_i != {`REG_ADDR_WIDTH{1'b0}}) & ~pending_q[wb_waddr_i])));
  end

  // State and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      info_q    <= {`DECINFO_WIDTH{1'b0}};
      we_q      <= 1'b0;
      long_q    <= 1'b0;
      waddr_q   <= {`REG_ADDR_WIDTH{1'b0}};
      rs1_q     <= {`REG_ADDR_WIDTH{1'b0}};
      rs2_q     <= {`REG_ADDR_WIDTH{1'b0}};
      pending_q <= 32'd0;
      cnt_q     <= {CNT_W{1'b0}};
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      info_q    <= info_d;
      we_q      <= we_d;
      long_q    <= long_d;
      waddr_q   <= waddr_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign dec_ready_o       = dec_ready_s;
  assign issue_valid_o     = issue_valid_s;
  assign issue_info_o      = info_q;
  assign issue_reg_we_o    = we_q;
  assign issue_reg_waddr_o = waddr_q;
  assign issue_long_o      = long_q;
  assign busy_o            = (state_q != ST_EMPTY) | (cnt_q != {CNT_W{1'b0}});
  assign err_o             = err_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed, table-driven bench for issue_ctrl: per-cycle vectors with
// hand-computed handshake/issue/busy/err expectations plus corner sequences.
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 16
`endif
`ifndef DECINFO_GRP_BUS
`define DECINFO_GRP_BUS 2:0
`define DECINFO_GRP_WIDTH 3
`define DECINFO_GRP_ALU 3'd0
`define DECINFO_GRP_BJP 3'd1
`define DECINFO_GRP_MULDIV 3'd2
`define DECINFO_GRP_CSR 3'd3
`define DECINFO_GRP_MEM 3'd4
`define DECINFO_GRP_SYS 3'd5
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module tb_issue_ctrl;

  localparam logic [2:0] ALU = `DECINFO_GRP_ALU;
  localparam logic [2:0] MUL = `DECINFO_GRP_MULDIV;
  localparam logic [2:0] MEM = `DECINFO_GRP_MEM;
  localparam logic [2:0] SYS = `DECINFO_GRP_SYS;

  logic        clk, rst_n;
  logic        dec_valid_i, dec_ready_o, reg_we_i;
  logic [15:0] dec_info_i, issue_info_o;
  logic [4:0]  reg1_raddr_i, reg2_raddr_i, reg_waddr_i, issue_reg_waddr_o, wb_waddr_i;
  logic        issue_valid_o, ex_ready_i, issue_reg_we_o, issue_long_o;
  logic        wb_valid_i, flush_i, busy_o, err_o;

  int checks = 0;
  int errors = 0;

  issue_ctrl #(.MAX_OUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_info_i(dec_info_i),
    .reg1_raddr_i(reg1_raddr_i), .reg2_raddr_i(reg2_raddr_i),
    .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i),
    .issue_valid_o(issue_valid_o), .ex_ready_i(ex_ready_i), .issue_info_o(issue_info_o),
    .issue_reg_we_o(issue_reg_we_o), .issue_reg_waddr_o(issue_reg_waddr_o),
    .issue_long_o(issue_long_o),
    .wb_valid_i(wb_valid_i), .wb_waddr_i(wb_waddr_i), .flush_i(flush_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       dv;
    logic [2:0] grp;
    logic [4:0] rs1, rs2;
    logic       we;
    logic [4:0] rd;
    logic       exr, wbv;
    logic [4:0] wba;
    logic       fl;
    logic       e_rdy, e_iv;
    logic [4:0] e_rd;
    logic       e_busy, e_err;
  } vec_t;

  function automatic vec_t V(input int dv, input logic [2:0] grp, input int rs1, input int rs2,
                             input int we, input int rd, input int exr, input int wbv,
                             input int wba, input int fl, input int e_rdy, input int e_iv,
                             input int e_rd, input int e_busy, input int e_err);
    vec_t v;
    v.dv = 1'(dv);   v.grp = grp;     v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.we = 1'(we);   v.rd = 5'(rd);   v.exr = 1'(exr); v.wbv = 1'(wbv);
    v.wba = 5'(wba); v.fl = 1'(fl);   v.e_rdy = 1'(e_rdy); v.e_iv = 1'(e_iv);
    v.e_rd = 5'(e_rd); v.e_busy = 1'(e_busy); v.e_err = 1'(e_err);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive at negedge, check combinational outputs, clock, then idle the strobes.
  task automatic step(input vec_t v, input string nm);
    @(negedge clk);
    dec_valid_i  = v.dv;
    dec_info_i   = {3'b101, v.rs1, v.rs2, v.grp};
    reg1_raddr_i = v.rs1;
    reg2_raddr_i = v.rs2;
    reg_we_i     = v.we;
    reg_waddr_i  = v.rd;
    ex_ready_i   = v.exr;
    wb_valid_i   = v.wbv;
    wb_waddr_i   = v.wba;
    flush_i      = v.fl;
    #1;
    chk({nm, ".dec_ready"}, 32'(dec_ready_o), 32'(v.e_rdy));
    chk({nm, ".issue_valid"}, 32'(issue_valid_o), 32'(v.e_iv));
    if (v.e_iv) chk({nm, ".issue_rd"}, 32'(issue_reg_waddr_o), 32'(v.e_rd));
    chk({nm, ".busy"}, 32'(busy_o), 32'(v.e_busy));
    chk({nm, ".err"}, 32'(err_o), 32'(v.e_err));
    @(posedge clk);
    #1;
    dec_valid_i = 1'b0;
    wb_valid_i  = 1'b0;
    flush_i     = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({nm, ".rst_issue_valid"}, 32'(issue_valid_o), 32'd0);
    chk({nm, ".rst_dec_ready"}, 32'(dec_ready_o), 32'd1);
    chk({nm, ".rst_busy"}, 32'(busy_o), 32'd0);
    chk({nm, ".rst_err"}, 32'(err_o), 32'd0);
    chk({nm, ".rst_info"}, 32'(issue_info_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; dec_valid_i = 1'b0; dec_info_i = 16'd0; reg1_raddr_i = 5'd0;
    reg2_raddr_i = 5'd0; reg_we_i = 1'b0; reg_waddr_i = 5'd0; ex_ready_i = 1'b1;
    wb_valid_i = 1'b0; wb_waddr_i = 5'd0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("init");

    // Back-to-back ALU, then load-use stall released by writeback.
    tbl.push_back(V(1, ALU, 0, 0, 1, 1,  1, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(V(1, ALU, 0, 0, 1, 2,  1, 0, 0, 0,  1, 1, 1, 1, 0));
    tbl.push_back(V(1, ALU, 0, 0, 1, 3,  1, 0, 0, 0,  1, 1, 2, 1, 0));
    tbl.push_back(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 3, 1, 0));
    tbl.push_back(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(V(1, MEM, 0, 0, 1, 5,  1, 0, 0, 0,  1, 0, 0, 0, 0));
    tbl.push_back(V(1, ALU, 5, 0, 1, 6,  1, 0, 0, 0,  1, 1, 5, 1, 0));
    tbl.push_back(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 1, 0));
    tbl.push_back(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 1, 0));
    tbl.push_back(V(0, ALU, 0, 0, 0, 0,  1, 1, 5, 0,  0, 0, 0, 1, 0));
    tbl.push_back(V(0, ALU, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 6, 1, 0));
    tbl.push_back(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 6, 1, 0));
    tbl.push_back(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));
    chk("pend5_cleared", 32'(dut.pending_q[5]), 32'd0);

    // Five divides against MAX_OUT=4.
    step(V(1, MUL, 0, 0, 1, 1,  1, 0, 0, 0,  1, 0, 0, 0, 0), "div1");
    for (int k = 2; k <= 5; k++)
      step(V(1, MUL, 0, 0, 1, k,  1, 0, 0, 0,  1, 1, k - 1, 1, 0), $sformatf("div%0d", k));
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 1, 0), "div_full0");
    chk("div_cnt_peak", 32'(dut.cnt_q), 32'd4);
    chk("div_long", 32'(issue_long_o), 32'd1);
    chk("div_info", 32'(issue_info_o), 32'({3'b101, 5'd0, 5'd0, 3'd2}));
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 1, 0), "div_full1");
    step(V(0, ALU, 0, 0, 0, 0,  1, 1, 1, 0,  0, 0, 0, 1, 0), "div_wb1");
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 5, 1, 0), "div5_issue");
    chk("div_cnt_again", 32'(dut.cnt_q), 32'd4);
    for (int k = 2; k <= 5; k++)
      step(V(0, ALU, 0, 0, 0, 0,  1, 1, k, 0,  1, 0, 0, 1, 0), $sformatf("div_wb%0d", k));
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0, 0), "div_idle");

    // ecall drains two outstanding loads.
    step(V(1, MEM, 0, 0, 1, 7,  1, 0, 0, 0,  1, 0, 0, 0, 0), "ld7");
    step(V(1, MEM, 0, 0, 1, 8,  1, 0, 0, 0,  1, 1, 7, 1, 0), "ld8");
    step(V(1, SYS, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 8, 1, 0), "ecall");
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 1, 0), "drain0");
    step(V(0, ALU, 0, 0, 0, 0,  1, 1, 7, 0,  0, 0, 0, 1, 0), "drain_wb7");
    step(V(0, ALU, 0, 0, 0, 0,  1, 1, 8, 0,  0, 0, 0, 1, 0), "drain_wb8");
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 0, 1, 0), "ecall_issue");
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0, 0), "ecall_idle");

    // Same-cycle writeback and long issue keep the count.
    step(V(1, MEM, 0, 0, 1, 9,  1, 0, 0, 0,  1, 0, 0, 0, 0), "ld9");
    step(V(1, MEM, 0, 0, 1, 10, 1, 0, 0, 0,  1, 1, 9, 1, 0), "ld10");
    step(V(0, ALU, 0, 0, 0, 0,  1, 1, 9, 0,  1, 1, 10, 1, 0), "wb9_issue10");
    chk("same_cnt", 32'(dut.cnt_q), 32'd1);
    chk("same_pend10", 32'(dut.pending_q[10]), 32'd1);
    chk("same_pend9", 32'(dut.pending_q[9]), 32'd0);
    step(V(0, ALU, 0, 0, 0, 0,  1, 1, 10, 0, 1, 0, 0, 1, 0), "wb10");

    // Flush of a hazarded entry beats a simultaneous accept.
    step(V(1, MEM, 0, 0, 1, 11, 1, 0, 0, 0,  1, 0, 0, 0, 0), "ld11");
    step(V(1, ALU, 0, 11, 1, 12, 1, 0, 0, 0, 1, 1, 11, 1, 0), "add_dep11");
    step(V(1, ALU, 0, 0, 1, 13, 1, 0, 0, 1,  0, 0, 0, 1, 0), "flush");
    chk("flush_pend11", 32'(dut.pending_q[11]), 32'd1);
    chk("flush_cnt", 32'(dut.cnt_q), 32'd1);
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 1, 0), "post_flush");
    step(V(0, ALU, 0, 0, 0, 0,  1, 1, 11, 0, 1, 0, 0, 1, 0), "wb11");
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0, 0), "flush_idle");

    // Writeback underflow sets a sticky error.
    step(V(0, ALU, 0, 0, 0, 0,  1, 1, 3, 0,  1, 0, 0, 0, 0), "wb_underflow");
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0, 1), "err_set");
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0, 1), "err_sticky");
    do_reset("err_clr");

    // Writeback to a non-pending register with count nonzero.
    step(V(1, MEM, 0, 0, 1, 13, 1, 0, 0, 0,  1, 0, 0, 0, 0), "ld13");
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 1, 13, 1, 0), "ld13_issue");
    step(V(0, ALU, 0, 0, 0, 0,  1, 1, 14, 0, 1, 0, 0, 1, 0), "wb14_bad");
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0, 1), "err_mismatch");
    do_reset("err_clr2");

    // Asynchronous reset discards a held entry without a clock edge.
    step(V(1, ALU, 3, 4, 1, 20, 0, 0, 0, 0,  1, 0, 0, 0, 0), "hold20");
    chk("hold_valid", 32'(issue_valid_o), 32'd1);
    chk("hold_info", 32'(issue_info_o), 32'({3'b101, 5'd3, 5'd4, 3'd0}));
    chk("hold_rd", 32'(issue_reg_waddr_o), 32'd20);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(issue_valid_o), 32'd0);
    chk("arst_info", 32'(issue_info_o), 32'd0);
    chk("arst_rd", 32'(issue_reg_waddr_o), 32'd0);
    chk("arst_we", 32'(issue_reg_we_o), 32'd0);
    chk("arst_long", 32'(issue_long_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_ready", 32'(dec_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ex_ready_i = 1'b1;
    step(V(0, ALU, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 0, 0, 0), "after_arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
